// File: rtl/rp32_mem.sv
// rp32_mem: dual-port tightly coupled SRAM model answering the rp32 program
// and data buses. Each port has its own request/ack FSM with a fixed number
// of wait states; the storage array is the only shared resource.

// Per-port handshake controller. Captures a request, counts down the wait
// states and raises a one-cycle access strobe. The strobe is fired from the
// live inputs when there are no wait states, otherwise from the captured copy.
module rp32_mem_port #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4,
  parameter int WS = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          wen,
  input  logic [SW-1:0] sel,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] wdt,
  output logic          ack,
  output logic          acc,
  output logic          acc_wen,
  output logic [SW-1:0] acc_sel,
  output logic [AW-1:0] acc_adr,
  output logic [DW-1:0] acc_wdt
);
  typedef enum logic {IDLE, BUSY} st_t;

  localparam logic [3:0] WSC = 4'(WS);

  st_t           state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q;
  logic          cap;
  logic          wen_q;
  logic [SW-1:0] sel_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdt_q;

  // a new request is taken when idle or in the ack cycle of the previous one
  assign cap = req && (state_q == IDLE || ack_q);

  // next state, wait countdown and access strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc     = 1'b0;
    if (cap) begin
      state_d = BUSY;
      cnt_d   = WSC;
      acc     = (WSC == 4'd0);
    end else if (state_q == BUSY) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
        acc   = (cnt_q == 4'd1);
      end else begin
        // ack cycle with no follow-on request
        state_d = IDLE;
      end
    end
  end

  // state register; ack is the access strobe delayed by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= acc;
    end
  end

  // request capture; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      wdt_q <= '0;
    end else if (cap) begin
      wen_q <= wen;
      sel_q <= sel;
      adr_q <= adr;
      wdt_q <= wdt;
    end
  end

  assign ack     = ack_q;
  assign acc_wen = cap ? wen : wen_q;
  assign acc_sel = cap ? sel : sel_q;
  assign acc_adr = cap ? adr : adr_q;
  assign acc_wdt = cap ? wdt : wdt_q;
endmodule

module rp32_mem #(
  parameter int PAW  = 32,
  parameter int PDW  = 32,
  parameter int DAW  = 32,
  parameter int DDW  = 32,
  parameter int SIZE = 4096,
  parameter int PWS  = 0,
  parameter int DWS  = 0,
  parameter int SW   = DDW/8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bup_req,
  input  logic [PAW-1:0] bup_adr,
  output logic [PDW-1:0] bup_dat,
  output logic           bup_ack,
  input  logic           bud_req,
  input  logic           bud_wen,
  input  logic [SW-1:0]  bud_sel,
  input  logic [DAW-1:0] bud_adr,
  input  logic [DDW-1:0] bud_wdt,
  output logic [DDW-1:0] bud_rdt,
  output logic           bud_ack
);
  localparam int AB    = $clog2(SIZE);
  localparam int IW    = (AB > 2) ? AB - 2 : 1;
  localparam int WORDS = SIZE / 4;

  logic [DDW-1:0] mem [WORDS];

  logic           p_acc, p_wen;
  logic [0:0]     p_sel;
  logic [PAW-1:0] p_adr;
  logic [PDW-1:0] p_wdt;
  logic           d_acc, d_wen;
  logic [SW-1:0]  d_sel;
  logic [DAW-1:0] d_adr;
  logic [DDW-1:0] d_wdt;
  logic [IW-1:0]  p_idx, d_idx;

  rp32_mem_port #(.AW(PAW), .DW(PDW), .SW(1), .WS(PWS)) u_pport (
    .clk(clk), .rst_n(rst_n), .req(bup_req), .wen(1'b0), .sel(1'b0),
    .adr(bup_adr), .wdt('0), .ack(bup_ack), .acc(p_acc), .acc_wen(p_wen),
    .acc_sel(p_sel), .acc_adr(p_adr), .acc_wdt(p_wdt)
  );

  rp32_mem_port #(.AW(DAW), .DW(DDW), .SW(SW), .WS(DWS)) u_dport (
    .clk(clk), .rst_n(rst_n), .req(bud_req), .wen(bud_wen), .sel(bud_sel),
    .adr(bud_adr), .wdt(bud_wdt), .ack(bud_ack), .acc(d_acc), .acc_wen(d_wen),
    .acc_sel(d_sel), .acc_adr(d_adr), .acc_wdt(d_wdt)
  );

  // word index: drop byte offset and everything above the array size
  assign p_idx = (AB > 2) ? IW'(p_adr >> 2) : '0;
  assign d_idx = (AB > 2) ? IW'(d_adr >> 2) : '0;

  // program read; non-blocking read gives old data on a same-edge write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     bup_dat <= '0;
    else if (p_acc) bup_dat <= mem[p_idx];
  end

  // data read; writes leave the read register untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               bud_rdt <= '0;
    else if (d_acc && !d_wen) bud_rdt <= mem[d_idx];
  end

  // byte-lane writes; storage has no reset
  always_ff @(posedge clk) begin
    if (rst_n && d_acc && d_wen)
      for (int i = 0; i < SW; i++)
        if (d_sel[i]) mem[d_idx][8*i +: 8] <= d_wdt[8*i +: 8];
  end
endmodule

// File: doc/rp32_mem.md
# rp32_mem

Single-clock, dual-port on-chip memory that is the responder for both rp32 core buses. The program port answers instruction fetches, and the data port answers loads and stores. Each port has an independently configurable wait-state count and a request/acknowledge handshake. The block sits between the core and the top level and models tightly coupled SRAM for simulation and FPGA builds.

## Interface
- `PAW`, 32, program address width (byte address)
- `PDW`, 32, program data width; only 32 is supported
- `DAW`, 32, data address width (byte address)
- `DDW`, 32, data data width; only 32 is supported; `SW = DDW/8` byte lanes
- `SIZE`, 4096, memory size in bytes; power of two, at least 4
- `PWS`, 0, program-port wait states (0..15)
- `DWS`, 0, data-port wait states (0..15)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `bup_req`  in  1  program fetch request
- `bup_adr`  in  `PAW`  program byte address
- `bup_dat`  out  `PDW`  fetched instruction word
- `bup_ack`  out  1  program transfer complete
- `bud_req`  in  1  data request
- `bud_wen`  in  1  write enable (1 = store, 0 = load)
- `bud_sel`  in  `SW`  byte select for writes
- `bud_adr`  in  `DAW`  data byte address
- `bud_wdt`  in  `DDW`  write data
- `bud_rdt`  out  `DDW`  read data
- `bud_ack`  out  1  data transfer complete

## Operation
- Storage is `SIZE/4` words. The word index is `adr[log2(SIZE)-1:2]`.
  - Address bits 1:0 are ignored.
  - Bits above `log2(SIZE)` are ignored, so addresses alias and wrap modulo `SIZE`.
- Each port runs an identical, independent FSM with two states, IDLE and BUSY, plus a 4-bit wait counter `cnt`.
  - **Capture.** A rising edge captures a request when `req`=1 and either the port is IDLE or `ack`=1 in the current cycle.
    - Address, `wen`, `sel` and `wdt` are registered.
    - `cnt` is loaded with the port's wait-state count (`PWS` or `DWS`), and the state becomes BUSY.
  - **BUSY, waiting.** While `cnt`≠0, each edge decrements `cnt`.
  - **BUSY, completing.** The edge on which `cnt` reaches 0 is the access edge. That is the same edge as capture when the wait-state count is 0.
    - Reads load `dat`/`rdt` from memory.
    - Writes update each byte lane i for which `sel[i]`=1.
  - **Acknowledge.** `ack`=1 for exactly the one cycle after the access edge.
  - **Ack-cycle edge.** At the edge that ends an ack cycle, a new request is captured if `req`=1; otherwise the port returns to IDLE.
- Data-port writes leave `bud_rdt` unchanged. A write with `sel`=0 completes normally and modifies no data.
- Reads always return the full word, regardless of `sel`.
- Simultaneous accesses to the same word on the same edge (program read plus data write) use read-before-write: `bup_dat` returns the old word.
- The initiator must hold its request signals stable from assertion until the ack cycle. Inputs sampled at capture are authoritative; later changes are ignored.
- Memory contents are not reset. Initialisation is by simulation or synthesis preload only.

## Timing
- **Reset values:** `bup_ack`=0, `bud_ack`=0, `bup_dat`=0, `bud_rdt`=0, both FSMs IDLE, `cnt`=0.
- **Latency:** request sampled at edge N gives `ack` in the cycle after edge N+WS, i.e. WS+1 cycles after the sampled request.
- **Data timing:** `dat`/`rdt` are valid in the ack cycle and hold that value until the next read access edge.
- **Throughput:** with WS=0 and `req` held high, one transfer completes per cycle; `ack` stays high continuously. With WS>0, one transfer completes per WS+1 cycles.
- **Deasserted request:** if `req` is deasserted before ack, the behaviour is unspecified. The initiator must not do this.
- **Reset mid-transaction:** asynchronous abort. `ack` drops immediately. A write whose access edge has not yet occurred is not performed.
- **Port independence:** the two ports share no state other than the storage array. Neither port ever stalls the other.

## Test plan
- **Read after write, zero wait:** with `DWS`=0, store 0xDEADBEEF to 0x10 with `sel`=1111, then load 0x10 → `bud_ack` is 1 cycle after each request and `bud_rdt`=0xDEADBEEF.
- **Byte lanes:** write 0x00000000 to 0x20, then write 0xAABBCCDD with `sel`=0101, then read → 0x00BB00DD. A write with `sel`=0000 leaves the word unchanged.
- **Wait states:** with `PWS`=3, hold `bup_req` high from cycle 0 → `bup_ack` pulses in cycles 4, 8 and 12, and `bup_dat` follows consecutive preloaded words as `bup_adr` steps by 4.
- **Collision:** preload 0x11111111 at 0x40. On the same edge, fetch 0x40 on the program port and write 0x22222222 on the data port → `bup_dat`=0x11111111; a subsequent fetch returns 0x22222222.
- **Wrap and aliasing:** with `SIZE`=4096, write 0x12345678 to 0x1004 and read 0x0004 → 0x12345678. A read of 0x0007 returns the same word.
- **Reset mid-transfer:** with `DWS`=2, assert `rst_n`=0 one cycle after a store is captured → `bud_ack`=0 immediately, and after reset a read of that address returns the old data.
